// File: rtl/pipeline_debug_dump.sv
// Debug controller for the Pipeline core: single-steps the core, snapshots its
// five observation buses plus a step counter, and streams a 25-byte frame over valid/ready.
module pipeline_debug_dump #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int         CNT_W  = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step_req,
  input  logic        rst_req,
  input  logic [31:0] pc_addr_in,
  input  logic [31:0] pc_instr_in,
  input  logic [31:0] w_data_in,
  input  logic [31:0] rt_data_in,
  input  logic [31:0] rs_data_in,
  output logic        pc_enable_out,
  output logic        pc_reset_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, CRST, STEP, SETTLE, CAPT, SEND} state_t;

  localparam logic [4:0] LAST_IDX = 5'd24;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pc_en;
  logic             r_pc_rst;
  logic             r_tx_valid;
  logic             r_done;
  logic [4:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic [31:0]      r_instr;
  logic [31:0]      r_wdat;
  logic [31:0]      r_rt;
  logic [31:0]      r_rs;
  logic             w_xfer;
  logic             w_last;
  logic [199:0]     w_frame;

  assign w_xfer  = (r_state == SEND) && r_tx_valid && tx_ready;
  assign w_last  = w_xfer && (r_idx == LAST_IDX);
  // Byte k of the frame sits at bits [8k+7:8k]; words therefore go out LSB first.
  assign w_frame = {32'(r_cnt), r_rs, r_rt, r_wdat, r_instr, r_addr, HEADER};

  assign pc_enable_out = r_pc_en;
  assign pc_reset_out  = r_pc_rst;
  assign tx_valid      = r_tx_valid;
  assign tx_data       = r_tx_valid ? w_frame[{r_idx, 3'b000} +: 8] : 8'h00;
  assign busy          = (r_state != IDLE);
  assign done          = r_done;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (rst_req)       w_state_nxt = CRST;
        else if (step_req) w_state_nxt = STEP;
      end
      CRST:    w_state_nxt = IDLE;
      STEP:    w_state_nxt = SETTLE;
      SETTLE:  w_state_nxt = CAPT;
      CAPT:    w_state_nxt = SEND;
      SEND: begin
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc_en    <= 1'b0;
      r_pc_rst   <= 1'b0;
      r_tx_valid <= 1'b0;
      r_done     <= 1'b0;
      r_idx      <= 5'd0;
      r_cnt      <= '0;
      r_addr     <= 32'd0;
      r_instr    <= 32'd0;
      r_wdat     <= 32'd0;
      r_rt       <= 32'd0;
      r_rs       <= 32'd0;
    end else begin
      // Control outputs are registered from the next state so they line up with it.
      r_pc_en    <= (w_state_nxt == STEP);
      r_pc_rst   <= (w_state_nxt == CRST);
      r_tx_valid <= (w_state_nxt == SEND);
      r_done     <= w_last;
      if (r_state == CRST)      r_cnt <= '0;
      else if (r_state == STEP) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == CAPT) begin
        r_addr  <= pc_addr_in;
        r_instr <= pc_instr_in;
        r_wdat  <= w_data_in;
        r_rt    <= rt_data_in;
        r_rs    <= rs_data_in;
        r_idx   <= 5'd0;
      end else if (w_xfer) begin
        r_idx <= w_last ? 5'd0 : r_idx + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_debug_dump.sv
// Randomised bench for pipeline_debug_dump: frames are compared byte-for-byte
// against a queue-based model of the frame layout and step counter.
module tb_pipeline_debug_dump;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        step_req;
  logic        rst_req;
  logic [31:0] pc_addr_in;
  logic [31:0] pc_instr_in;
  logic [31:0] w_data_in;
  logic [31:0] rt_data_in;
  logic [31:0] rs_data_in;
  logic        pc_enable_out;
  logic        pc_reset_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  int unsigned m_cnt  = 0;

  always #5 clk = ~clk;

  pipeline_debug_dump dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .step_req      (step_req),
    .rst_req       (rst_req),
    .pc_addr_in    (pc_addr_in),
    .pc_instr_in   (pc_instr_in),
    .w_data_in     (w_data_in),
    .rt_data_in    (rt_data_in),
    .rs_data_in    (rs_data_in),
    .pc_enable_out (pc_enable_out),
    .pc_reset_out  (pc_reset_out),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},   pc_enable_out, 0);
    chk({tag, "_rst"},  pc_reset_out, 0);
    chk({tag, "_vld"},  tx_valid, 0);
    chk({tag, "_dat"},  tx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // mode 0: ready always high, 1: ready one cycle in three, 2: random ready.
  task automatic step_frame(input bit rnd, input int mode, input bit inject, input int abort_at);
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [31:0] words[6];
    logic [7:0]  prev_dat;
    int          first_v, last_k, n_en, n_rst, extra;
    bit          seen_done, prev_stall, aborted;
    if (rnd) begin
      pc_addr_in  = $urandom;
      pc_instr_in = $urandom;
      w_data_in   = $urandom;
      rt_data_in  = $urandom;
      rs_data_in  = $urandom;
    end
    m_cnt = m_cnt + 1;
    words = '{pc_addr_in, pc_instr_in, w_data_in, rt_data_in, rs_data_in, m_cnt};
    exp_q.push_back(8'hA5);
    for (int w = 0; w < 6; w++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(8'(words[w] >> (8 * b)));

    @(posedge clk); #1;
    step_req = 1'b1;
    @(posedge clk); #1;
    step_req = 1'b0;
    first_v = -1; last_k = -1; n_en = 0; n_rst = 0;
    seen_done = 1'b0; prev_stall = 1'b0; aborted = 1'b0; prev_dat = 8'h00;
    for (int k = 0; k < 400 && !seen_done && !aborted; k++) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (k % 3 == 2);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      step_req = inject && (got_q.size() == 5);
      @(negedge clk);
      if (pc_enable_out) n_en++;
      if (pc_reset_out)  n_rst++;
      if (k == 0) chk("busy_in_step", busy, 1);
      if (tx_valid && first_v < 0) begin
        first_v = k;
        chk("first_vld_lat", k, 3);
      end
      if (prev_stall) begin
        chk("hold_vld", tx_valid, 1);
        chk("hold_dat", tx_data, prev_dat);
      end
      if (done) begin
        seen_done = 1'b1;
        chk("done_lat", k, last_k + 1);
        chk("done_vld_low", tx_valid, 0);
      end
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        last_k = k;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_dat   = tx_data;
      @(posedge clk); #1;
      if (abort_at >= 0 && got_q.size() == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk_all_zero("abort");
        @(posedge clk); #1;
        reset_n = 1'b1;
        aborted = 1'b1;
        m_cnt   = 0;
      end
    end
    step_req = 1'b0;
    if (!aborted) begin
      chk("done_seen", seen_done, 1);
      chk("pc_en_pulses", n_en, 1);
      chk("pc_rst_pulses", n_rst, 0);
      chk("nbytes", got_q.size(), 25);
      for (int i = 0; i < 25; i++)
        chk($sformatf("byte%0d", i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      extra = 0;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        if (pc_enable_out || tx_valid || done || busy) extra++;
      end
      chk("idle_after_frame", extra, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic core_reset(input bit with_step);
    int n_en, n_rst, n_v;
    n_en = 0; n_rst = 0; n_v = 0;
    @(posedge clk); #1;
    rst_req  = 1'b1;
    step_req = with_step;
    @(posedge clk); #1;
    rst_req  = 1'b0;
    step_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) chk("crst_now", pc_reset_out, 1);
      if (pc_enable_out)    n_en++;
      if (pc_reset_out)     n_rst++;
      if (tx_valid || done) n_v++;
      @(posedge clk); #1;
    end
    chk("crst_rst_pulses", n_rst, 1);
    chk("crst_en_pulses", n_en, 0);
    chk("crst_no_frame", n_v, 0);
    m_cnt = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n_en;
    reset_n     = 1'b0;
    step_req    = 1'b1;
    rst_req     = 1'b0;
    tx_ready    = 1'b1;
    pc_addr_in  = 32'h0;
    pc_instr_in = 32'h0;
    w_data_in   = 32'h0;
    rt_data_in  = 32'h0;
    rs_data_in  = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_all_zero("reset");
    end
    @(posedge clk); #1;
    step_req = 1'b0;
    reset_n  = 1'b1;
    n_en = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (pc_enable_out || busy) n_en++;
    end
    chk("post_reset_idle", n_en, 0);

    pc_addr_in  = 32'h4;
    pc_instr_in = 32'h2001000A;
    w_data_in   = 32'hA;
    rt_data_in  = 32'h0;
    rs_data_in  = 32'h11223344;
    step_frame(1'b0, 0, 1'b0, -1);
    step_frame(1'b0, 1, 1'b0, -1);

    core_reset(1'b1);
    step_frame(1'b1, 2, 1'b0, -1);

    step_frame(1'b1, 1, 1'b1, -1);
    core_reset(1'b0);
    for (int i = 0; i < 3; i++) step_frame(1'b1, 0, 1'b0, -1);

    step_frame(1'b1, 2, 1'b0, 10);
    step_frame(1'b1, 0, 1'b0, -1);

    for (int i = 0; i < 6; i++) step_frame(1'b1, i % 3, i[0], -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
